dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache with its miss-handling state machine, sitting in the C (memory) stage. It serves load/store requests from the pipeline, fills and evicts lines over a handshaked line-wide memory port, and drives `busy_out`. `busy_out` is the dcache-busy signal the hazard unit turns into stall_F/D/A/C and flush_WB.

---
 rtl/brisc_pkg.sv | 13 +
 rtl/dcache_ctrl_if.sv | 28 ++
 rtl/dcache_store.sv | 57 +++++
 rtl/dcache_ctrl.sv | 88 ++++++++
 tb/tb_dcache_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/brisc_pkg.sv
// brisc_pkg: shared types and data-cache geometry for the brisc core
package brisc_pkg;
  typedef enum logic {BYTE, WORD} mem_size_e;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} dcache_state_e;
  typedef enum logic [1:0] {WR_NONE, WR_FILL, WR_MERGE, WR_CLEAN} dcache_wr_e;
  localparam int DCACHE_LINES = 4;
  localparam int DCACHE_LINE_BITS = 128;
  localparam int DCACHE_ADDR_BITS = 32;
  localparam int DCACHE_WORD_BITS = 32;
  localparam int DCACHE_OFF_BITS = $clog2(DCACHE_LINE_BITS / 8);
  localparam int DCACHE_IDX_BITS = $clog2(DCACHE_LINES);
  localparam int DCACHE_TAG_BITS = DCACHE_ADDR_BITS - DCACHE_IDX_BITS - DCACHE_OFF_BITS;
endpackage

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: pipeline request and line-wide memory port of the data cache
interface dcache_ctrl_if import brisc_pkg::*; #(
  parameter int ADDR_BITS = DCACHE_ADDR_BITS,
  parameter int WORD_BITS = DCACHE_WORD_BITS,
  parameter int LINE_BITS = DCACHE_LINE_BITS
) ();
  logic                 req_valid_in;
  logic                 req_we_in;
  mem_size_e            req_size_in;
  logic [ADDR_BITS-1:0] addr_in;
  logic [WORD_BITS-1:0] wdata_in;
  logic [WORD_BITS-1:0] rdata_out;
  logic                 busy_out;
  logic                 mem_req_out;
  logic                 mem_we_out;
  logic [ADDR_BITS-1:0] mem_addr_out;
  logic [LINE_BITS-1:0] mem_wdata_out;
  logic                 mem_ready_in;
  logic [LINE_BITS-1:0] mem_rdata_in;
  modport master (
    output req_valid_in, req_we_in, req_size_in, addr_in, wdata_in, mem_ready_in, mem_rdata_in,
    input  rdata_out, busy_out, mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out
  );
  modport slave (
    input  req_valid_in, req_we_in, req_size_in, addr_in, wdata_in, mem_ready_in, mem_rdata_in,
    output rdata_out, busy_out, mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out
  );
endinterface

// File: rtl/dcache_store.sv
// dcache_store: tag/valid/dirty/data arrays with one read port and one write port
module dcache_store import brisc_pkg::*; #(
  parameter int NUM_LINES = DCACHE_LINES,
  parameter int LINE_BITS = DCACHE_LINE_BITS,
  parameter int WORD_BITS = DCACHE_WORD_BITS,
  parameter int OFF_BITS  = DCACHE_OFF_BITS,
  parameter int IDX_BITS  = DCACHE_IDX_BITS,
  parameter int TAG_BITS  = DCACHE_TAG_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_BITS-1:0]  rd_idx_i,
  output logic                 rd_valid_o,
  output logic                 rd_dirty_o,
  output logic [TAG_BITS-1:0]  rd_tag_o,
  output logic [LINE_BITS-1:0] rd_line_o,
  input  dcache_wr_e           wr_op_i,
  input  logic [IDX_BITS-1:0]  wr_idx_i,
  input  logic [TAG_BITS-1:0]  wr_tag_i,
  input  logic [LINE_BITS-1:0] wr_line_i,
  input  logic [OFF_BITS-1:0]  wr_off_i,
  input  mem_size_e            wr_size_i,
  input  logic [WORD_BITS-1:0] wr_wdata_i
);
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];
  logic [LINE_BITS-1:0] merged;
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];
  // Store data merged into the addressed line: aligned word or single byte
  always_comb begin
    merged = data_q[wr_idx_i];
    if (wr_size_i == WORD) merged[{wr_off_i[OFF_BITS-1:2], 5'b0} +: WORD_BITS] = wr_wdata_i;
    else merged[{wr_off_i, 3'b0} +: 8] = wr_wdata_i[7:0];
  end
  // Line status bits: a fill installs a clean valid line, a merge dirties it, a writeback cleans it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_op_i == WR_FILL) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= 1'b0;
    end else if (wr_op_i == WR_MERGE) dirty_q[wr_idx_i] <= 1'b1;
    else if (wr_op_i == WR_CLEAN) dirty_q[wr_idx_i] <= 1'b0;
  end
  // Tag and data arrays are not reset; valid bits guard them
  always_ff @(posedge clk) begin
    if (wr_op_i == WR_FILL) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end else if (wr_op_i == WR_MERGE) data_q[wr_idx_i] <= merged;
  end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back data cache with miss FSM and line memory port
module dcache_ctrl import brisc_pkg::*; #(
  parameter int NUM_LINES = DCACHE_LINES,
  parameter int LINE_BITS = DCACHE_LINE_BITS,
  parameter int ADDR_BITS = DCACHE_ADDR_BITS,
  parameter int WORD_BITS = DCACHE_WORD_BITS
) (
  input logic         clk,
  input logic         reset,
  dcache_ctrl_if.slave bus
);
  localparam int OFF_BITS = $clog2(LINE_BITS / 8);
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = ADDR_BITS - IDX_BITS - OFF_BITS;
  dcache_state_e        state_q, state_d;
  dcache_wr_e           wr_op;
  logic [TAG_BITS-1:0]  miss_tag_q, addr_tag, rd_tag;
  logic [IDX_BITS-1:0]  miss_idx_q, addr_idx, rd_idx;
  logic [OFF_BITS-1:0]  addr_off;
  logic [LINE_BITS-1:0] rd_line;
  logic                 rd_valid, rd_dirty, hit;
  assign addr_tag = bus.addr_in[ADDR_BITS-1 -: TAG_BITS];
  assign addr_idx = bus.addr_in[OFF_BITS +: IDX_BITS];
  assign addr_off = bus.addr_in[OFF_BITS-1:0];
  assign rd_idx   = (state_q == IDLE) ? addr_idx : miss_idx_q;
  assign hit      = (state_q == IDLE) & bus.req_valid_in & rd_valid & (rd_tag == addr_tag);
  assign bus.rdata_out = !hit ? '0
                       : (bus.req_size_in == BYTE) ? {{(WORD_BITS-8){1'b0}}, rd_line[{addr_off, 3'b0} +: 8]}
                       : rd_line[{addr_off[OFF_BITS-1:2], 5'b0} +: WORD_BITS];
  assign bus.busy_out = !reset & ((state_q != IDLE) | (bus.req_valid_in & !hit));
  dcache_store #(
    .NUM_LINES(NUM_LINES), .LINE_BITS(LINE_BITS), .WORD_BITS(WORD_BITS),
    .OFF_BITS(OFF_BITS), .IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS)
  ) u_store (
    .clk(clk), .reset(reset),
    .rd_idx_i(rd_idx), .rd_valid_o(rd_valid), .rd_dirty_o(rd_dirty), .rd_tag_o(rd_tag), .rd_line_o(rd_line),
    .wr_op_i(wr_op), .wr_idx_i(rd_idx), .wr_tag_i(miss_tag_q), .wr_line_i(bus.mem_rdata_in),
    .wr_off_i(addr_off), .wr_size_i(bus.req_size_in), .wr_wdata_i(bus.wdata_in)
  );
  // State register and miss-address latch, captured in the cycle the miss is seen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) & bus.req_valid_in & !hit) begin
        miss_tag_q <= addr_tag;
        miss_idx_q <= addr_idx;
      end
    end
  end
  // Next state, array write and memory-port drive; victim data is read live since nothing writes it mid-writeback
  always_comb begin
    state_d           = state_q;
    wr_op             = WR_NONE;
    bus.mem_req_out   = 1'b0;
    bus.mem_we_out    = 1'b0;
    bus.mem_addr_out  = '0;
    bus.mem_wdata_out = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_in & !hit) state_d = (rd_valid & rd_dirty) ? WRITEBACK : FILL;
        else if (hit & bus.req_we_in) wr_op = WR_MERGE;
      end
      WRITEBACK: begin
        bus.mem_req_out   = 1'b1;
        bus.mem_we_out    = 1'b1;
        bus.mem_addr_out  = {rd_tag, miss_idx_q, {OFF_BITS{1'b0}}};
        bus.mem_wdata_out = rd_line;
        if (bus.mem_ready_in) begin
          wr_op   = WR_CLEAN;
          state_d = FILL;
        end
      end
      FILL: begin
        bus.mem_req_out  = 1'b1;
        bus.mem_addr_out = {miss_tag_q, miss_idx_q, {OFF_BITS{1'b0}}};
        if (bus.mem_ready_in) begin
          wr_op   = WR_FILL;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed scenarios for the data cache with hand-computed expectations
module tb_dcache_ctrl;
  import brisc_pkg::*;
  localparam logic [127:0] L1  = 128'h44444444_33333333_22222222_DDCCBBAA;
  localparam logic [127:0] L1M = 128'h44444444_33333333_22222222_5ACCBBAA;
  localparam logic [127:0] L2  = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] L4  = 128'h00000000_00000000_00000000_12345678;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int pass_n = 0;
  int total_n = 0;
  dcache_ctrl_if bus ();
  dcache_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic req(input logic v, input logic we, input mem_size_e sz, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid_in = v;
    bus.req_we_in    = we;
    bus.req_size_in  = sz;
    bus.addr_in      = a;
    bus.wdata_in     = d;
  endtask

  task automatic test_reset;
    req(1'b0, 1'b0, WORD, 32'h0, 32'h0);
    bus.mem_ready_in = 1'b0;
    bus.mem_rdata_in = '0;
    reset = 1'b1;
    cyc();
    cyc();
    #1;
    total_n++; if (bus.busy_out !== 1'b0) $display("FAIL rst_busy got %0b exp 0", bus.busy_out); else pass_n++;
    total_n++; if (bus.mem_req_out !== 1'b0) $display("FAIL rst_mem_req got %0b exp 0", bus.mem_req_out); else pass_n++;
    total_n++; if (bus.mem_we_out !== 1'b0) $display("FAIL rst_mem_we got %0b exp 0", bus.mem_we_out); else pass_n++;
    total_n++; if (bus.mem_addr_out !== 32'h0) $display("FAIL rst_mem_addr got %h exp 0", bus.mem_addr_out); else pass_n++;
    total_n++; if (bus.mem_wdata_out !== 128'h0) $display("FAIL rst_mem_wdata got %h exp 0", bus.mem_wdata_out); else pass_n++;
    total_n++; if (bus.rdata_out !== 32'h0) $display("FAIL rst_rdata got %h exp 0", bus.rdata_out); else pass_n++;
    reset = 1'b0;
    cyc();
    #1;
    total_n++; if (bus.busy_out !== 1'b0) $display("FAIL idle_busy got %0b exp 0", bus.busy_out); else pass_n++;
  endtask

  task automatic test_clean_miss;
    req(1'b1, 1'b0, WORD, 32'h100, 32'h0);
    #1;
    total_n++; if (bus.busy_out !== 1'b1) $display("FAIL cm_miss_busy got %0b exp 1", bus.busy_out); else pass_n++;
    total_n++; if (bus.mem_req_out !== 1'b0) $display("FAIL cm_idle_req got %0b exp 0", bus.mem_req_out); else pass_n++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      total_n++; if (bus.busy_out !== 1'b1) $display("FAIL cm_fill_busy%0d got %0b exp 1", i, bus.busy_out); else pass_n++;
      total_n++; if ({bus.mem_req_out, bus.mem_we_out} !== 2'b10) $display("FAIL cm_fill_req%0d got %b exp 10", i, {bus.mem_req_out, bus.mem_we_out}); else pass_n++;
      total_n++; if (bus.mem_addr_out !== 32'h100) $display("FAIL cm_fill_addr%0d got %h exp 100", i, bus.mem_addr_out); else pass_n++;
    end
    bus.mem_ready_in = 1'b1;
    bus.mem_rdata_in = L1;
    cyc();
    bus.mem_ready_in = 1'b0;
    #1;
    total_n++; if (bus.busy_out !== 1'b0) $display("FAIL cm_done_busy got %0b exp 0", bus.busy_out); else pass_n++;
    total_n++; if (bus.rdata_out !== 32'hDDCCBBAA) $display("FAIL cm_rdata got %h exp DDCCBBAA", bus.rdata_out); else pass_n++;
    total_n++; if (bus.mem_req_out !== 1'b0) $display("FAIL cm_done_req got %0b exp 0", bus.mem_req_out); else pass_n++;
  endtask

  task automatic test_store_hit;
    req(1'b1, 1'b1, BYTE, 32'h103, 32'h0000005A);
    #1;
    total_n++; if (bus.busy_out !== 1'b0) $display("FAIL sh_busy got %0b exp 0", bus.busy_out); else pass_n++;
    cyc();
    req(1'b1, 1'b0, WORD, 32'h100, 32'h0);
    #1;
    total_n++; if (bus.busy_out !== 1'b0) $display("FAIL sh_load_busy got %0b exp 0", bus.busy_out); else pass_n++;
    total_n++; if (bus.rdata_out !== 32'h5ACCBBAA) $display("FAIL sh_word got %h exp 5ACCBBAA", bus.rdata_out); else pass_n++;
    req(1'b1, 1'b0, BYTE, 32'h101, 32'h0);
    #1;
    total_n++; if (bus.rdata_out !== 32'h000000BB) $display("FAIL sh_byte got %h exp 000000BB", bus.rdata_out); else pass_n++;
  endtask

  task automatic test_dirty_miss;
    req(1'b1, 1'b0, WORD, 32'h140, 32'h0);
    #1;
    total_n++; if (bus.busy_out !== 1'b1) $display("FAIL dm_busy got %0b exp 1", bus.busy_out); else pass_n++;
    cyc();
    #1;
    total_n++; if ({bus.mem_req_out, bus.mem_we_out} !== 2'b11) $display("FAIL dm_wb_req got %b exp 11", {bus.mem_req_out, bus.mem_we_out}); else pass_n++;
    total_n++; if (bus.mem_addr_out !== 32'h100) $display("FAIL dm_wb_addr got %h exp 100", bus.mem_addr_out); else pass_n++;
    total_n++; if (bus.mem_wdata_out !== L1M) $display("FAIL dm_wb_data got %h exp %h", bus.mem_wdata_out, L1M); else pass_n++;
    bus.mem_ready_in = 1'b1;
    cyc();
    bus.mem_ready_in = 1'b0;
    #1;
    total_n++; if ({bus.mem_req_out, bus.mem_we_out} !== 2'b10) $display("FAIL dm_fill_req got %b exp 10", {bus.mem_req_out, bus.mem_we_out}); else pass_n++;
    total_n++; if (bus.mem_addr_out !== 32'h140) $display("FAIL dm_fill_addr got %h exp 140", bus.mem_addr_out); else pass_n++;
    total_n++; if (bus.busy_out !== 1'b1) $display("FAIL dm_fill_busy got %0b exp 1", bus.busy_out); else pass_n++;
    bus.mem_ready_in = 1'b1;
    bus.mem_rdata_in = L2;
    cyc();
    bus.mem_ready_in = 1'b0;
    #1;
    total_n++; if (bus.busy_out !== 1'b0) $display("FAIL dm_done_busy got %0b exp 0", bus.busy_out); else pass_n++;
    total_n++; if (bus.rdata_out !== 32'hA0A0A0A0) $display("FAIL dm_rdata got %h exp A0A0A0A0", bus.rdata_out); else pass_n++;
  endtask

  task automatic test_stall;
    req(1'b1, 1'b0, WORD, 32'h100, 32'h0);
    #1;
    total_n++; if (bus.busy_out !== 1'b1) $display("FAIL st_busy got %0b exp 1", bus.busy_out); else pass_n++;
    cyc();
    #1;
    total_n++; if (bus.mem_we_out !== 1'b0) $display("FAIL st_clean_victim got we=%0b exp 0", bus.mem_we_out); else pass_n++;
    for (int i = 0; i < 10; i++) begin
      cyc();
      #1;
      total_n++; if ({bus.busy_out, bus.mem_req_out, bus.mem_we_out} !== 3'b110) $display("FAIL st_hold%0d got %b exp 110", i, {bus.busy_out, bus.mem_req_out, bus.mem_we_out}); else pass_n++;
      total_n++; if (bus.mem_addr_out !== 32'h100) $display("FAIL st_addr%0d got %h exp 100", i, bus.mem_addr_out); else pass_n++;
    end
    bus.mem_ready_in = 1'b1;
    bus.mem_rdata_in = L1M;
    cyc();
    bus.mem_ready_in = 1'b0;
    #1;
    total_n++; if (bus.busy_out !== 1'b0) $display("FAIL st_done_busy got %0b exp 0", bus.busy_out); else pass_n++;
    total_n++; if (bus.rdata_out !== 32'h5ACCBBAA) $display("FAIL st_rdata got %h exp 5ACCBBAA", bus.rdata_out); else pass_n++;
  endtask

  task automatic test_reset_mid_fill;
    req(1'b1, 1'b0, WORD, 32'h140, 32'h0);
    cyc();
    #1;
    total_n++; if ({bus.mem_req_out, bus.mem_addr_out} !== {1'b1, 32'h140}) $display("FAIL rm_fill got req=%0b addr=%h exp 1/140", bus.mem_req_out, bus.mem_addr_out); else pass_n++;
    cyc();
    reset = 1'b1;
    #1;
    total_n++; if (bus.mem_req_out !== 1'b0) $display("FAIL rm_req got %0b exp 0", bus.mem_req_out); else pass_n++;
    total_n++; if (bus.busy_out !== 1'b0) $display("FAIL rm_busy got %0b exp 0", bus.busy_out); else pass_n++;
    cyc();
    reset = 1'b0;
    req(1'b1, 1'b0, WORD, 32'h100, 32'h0);
    #1;
    total_n++; if (bus.busy_out !== 1'b1) $display("FAIL rm_remiss got %0b exp 1", bus.busy_out); else pass_n++;
    cyc();
    #1;
    total_n++; if ({bus.mem_req_out, bus.mem_we_out, bus.mem_addr_out} !== {2'b10, 32'h100}) $display("FAIL rm_refill got %b/%h exp 10/100", {bus.mem_req_out, bus.mem_we_out}, bus.mem_addr_out); else pass_n++;
    bus.mem_ready_in = 1'b1;
    bus.mem_rdata_in = L1M;
    cyc();
    bus.mem_ready_in = 1'b0;
    #1;
    total_n++; if (bus.rdata_out !== 32'h5ACCBBAA) $display("FAIL rm_rdata got %h exp 5ACCBBAA", bus.rdata_out); else pass_n++;
  endtask

  task automatic test_flush_mid_fill;
    req(1'b1, 1'b1, WORD, 32'h180, 32'hCAFEF00D);
    #1;
    total_n++; if (bus.busy_out !== 1'b1) $display("FAIL fl_busy got %0b exp 1", bus.busy_out); else pass_n++;
    cyc();
    #1;
    total_n++; if ({bus.mem_we_out, bus.mem_addr_out} !== {1'b0, 32'h180}) $display("FAIL fl_fill got %0b/%h exp 0/180", bus.mem_we_out, bus.mem_addr_out); else pass_n++;
    bus.req_valid_in = 1'b0;
    cyc();
    #1;
    total_n++; if (bus.mem_req_out !== 1'b1) $display("FAIL fl_inflight got %0b exp 1", bus.mem_req_out); else pass_n++;
    bus.mem_ready_in = 1'b1;
    bus.mem_rdata_in = L4;
    cyc();
    bus.mem_ready_in = 1'b0;
    #1;
    total_n++; if ({bus.busy_out, bus.mem_req_out} !== 2'b00) $display("FAIL fl_done got %b exp 00", {bus.busy_out, bus.mem_req_out}); else pass_n++;
    req(1'b1, 1'b0, WORD, 32'h180, 32'h0);
    #1;
    total_n++; if (bus.busy_out !== 1'b0) $display("FAIL fl_hit got busy %0b exp 0", bus.busy_out); else pass_n++;
    total_n++; if (bus.rdata_out !== 32'h12345678) $display("FAIL fl_nomerge got %h exp 12345678", bus.rdata_out); else pass_n++;
    req(1'b1, 1'b0, WORD, 32'h1C0, 32'h0);
    cyc();
    #1;
    total_n++; if ({bus.mem_we_out, bus.mem_addr_out} !== {1'b0, 32'h1C0}) $display("FAIL fl_clean got %0b/%h exp 0/1C0", bus.mem_we_out, bus.mem_addr_out); else pass_n++;
    bus.mem_ready_in = 1'b1;
    bus.mem_rdata_in = L2;
    cyc();
    bus.mem_ready_in = 1'b0;
    bus.req_valid_in = 1'b0;
    #1;
    total_n++; if (bus.busy_out !== 1'b0) $display("FAIL fl_end_busy got %0b exp 0", bus.busy_out); else pass_n++;
  endtask

  task automatic test_idle_ready;
    bus.mem_ready_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      #1;
      total_n++; if ({bus.busy_out, bus.mem_req_out} !== 2'b00) $display("FAIL ir_idle%0d got %b exp 00", i, {bus.busy_out, bus.mem_req_out}); else pass_n++;
    end
    bus.mem_ready_in = 1'b0;
    req(1'b1, 1'b0, BYTE, 32'h1C7, 32'h0);
    #1;
    total_n++; if ({bus.busy_out, bus.rdata_out} !== {1'b0, 32'h000000A1}) $display("FAIL ir_hit got %0b/%h exp 0/000000A1", bus.busy_out, bus.rdata_out); else pass_n++;
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_store_hit();
    test_dirty_miss();
    test_stall();
    test_reset_mid_fill();
    test_flush_mid_fill();
    test_idle_ready();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
